// File: rtl/vic_pkg.sv
// Shared constants, state encoding and vector-address helper for the
// vectored interrupt controller.
package vic_pkg;

    // Number of external interrupt sources (source numbers 1..NUM_SRC).
    localparam int NUM_SRC  = 31;

    // Field positions inside the 4-bit configuration registers.
    localparam int EN_BIT   = 3;
    localparam int PRIO_MSB = 2;
    localparam int GIE_BIT  = 0;

    // Reset values.
    localparam logic [3:0]  REG0_RST = 4'b0001;
    localparam logic [3:0]  CFG_RST  = 4'b0000;
    localparam logic [31:0] ADDR_RST = 32'h0000_0000;
    localparam logic [3:0]  CC_RST   = 4'b0000;

    // Service state: either running normal code or inside a handler.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } vic_state_e;

    // Vector address for source number src.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input int unsigned shift,
                                             input logic [4:0]  src);
        vec_addr = base + ({27'd0, src} << shift);
    endfunction

endpackage

// File: rtl/vic_arbiter.sv
// Combinational arbiter: picks the pending source with the highest
// priority; among equal priorities the lowest source number wins.
module vic_arbiter
    import vic_pkg::*;
(
    input  logic [NUM_SRC-1:0]             i_pend,
    input  logic [NUM_SRC-1:0][PRIO_MSB:0] i_prio,
    output logic                           o_valid,
    output logic [4:0]                     o_winner
);

    logic              found_s;
    logic [PRIO_MSB:0] best_s;
    logic [4:0]        win_s;

    // Ascending scan; only a strictly higher priority displaces the current
    // candidate, so ties keep the lower index.
    always_comb begin
        found_s = 1'b0;
        best_s  = 3'd0;
        win_s   = 5'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_pend[k] && (!found_s || (i_prio[k] > best_s))) begin
                found_s = 1'b1;
                best_s  = i_prio[k];
                win_s   = 5'(k + 1);
            end else begin
                found_s = found_s;
            end
        end
        o_valid  = found_s;
        o_winner = win_s;
    end

endmodule

// File: rtl/vic_ctrl.sv
// Vectored interrupt controller: register file, request edge capture,
// pending bits and the entry / return sequencing towards fetch.
module vic_ctrl
    import vic_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_PC,
    input  logic [3:0]         i_VIC_data,
    input  logic [4:0]         i_VIC_regaddr,
    input  logic               i_VIC_we,
    input  logic [NUM_SRC-1:0] i_ext,
    input  logic               i_reti,
    input  logic [3:0]         i_CCodes,
    output logic [3:0]         o_CCodes,
    output logic [3:0]         o_VIC_data,
    output logic [31:0]        o_VIC_iaddr,
    output logic               o_VIC_ctrl
);

    // Register file
    logic                           gie_q, gie_d;
    logic [3:0]                     cfg_q [1:NUM_SRC];
    logic [3:0]                     cfg_d [1:NUM_SRC];
    logic [NUM_SRC:0][3:0]          rd_arr_s;

    // Request capture
    logic [NUM_SRC-1:0]             ext_q, ext_d;
    logic [NUM_SRC-1:0]             pend_q, pend_d;
    logic [NUM_SRC-1:0]             rise_s;
    logic [NUM_SRC-1:0]             en_cur_s;
    logic [NUM_SRC-1:0]             en_nxt_s;
    logic [NUM_SRC-1:0][PRIO_MSB:0] prio_s;

    // Sequencing
    vic_state_e                     state_q, state_d;
    logic                           win_valid_s;
    logic [4:0]                     win_s;
    logic [4:0]                     win_idx_s;
    logic                           take_s;
    logic                           ret_s;
    logic [31:0]                    saved_pc_q, saved_pc_d;
    logic [3:0]                     saved_cc_q, saved_cc_d;
    logic [31:0]                    iaddr_q, iaddr_d;
    logic                           ctrl_q, ctrl_d;

    // Next register-file contents; reg0 keeps only the GIE bit.
    always_comb begin
        gie_d = gie_q;
        if (i_VIC_we && (i_VIC_regaddr == 5'd0)) begin
            gie_d = i_VIC_data[GIE_BIT];
        end else begin
            gie_d = gie_q;
        end
        for (int n = 1; n <= NUM_SRC; n++) begin
            if (i_VIC_we && (i_VIC_regaddr == 5'(n))) begin
                cfg_d[n] = i_VIC_data;
            end else begin
                cfg_d[n] = cfg_q[n];
            end
        end
    end

    // Combinational read port; unused reg0 bits read as zero.
    always_comb begin
        rd_arr_s[0] = {3'b000, gie_q};
        for (int n = 1; n <= NUM_SRC; n++) begin
            rd_arr_s[n] = cfg_q[n];
        end
        o_VIC_data = rd_arr_s[i_VIC_regaddr];
    end

    // Per-source enable (current and after this cycle's write) and priority.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            en_cur_s[k] = cfg_q[k + 1][EN_BIT];
            en_nxt_s[k] = cfg_d[k + 1][EN_BIT];
            prio_s[k]   = cfg_q[k + 1][PRIO_MSB:0];
        end
    end

    // Rising-edge detect on the raw request lines.
    always_comb begin
        ext_d  = i_ext;
        rise_s = i_ext & ~ext_q;
    end

    vic_arbiter u_arb (
        .i_pend   (pend_q),
        .i_prio   (prio_s),
        .o_valid  (win_valid_s),
        .o_winner (win_s)
    );

    // Service state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Service next-state: enter on a take, leave on a return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    state_d = ST_ISR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISR: begin
                if (ret_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Service decode: a take is only possible outside a handler, so it can
    // never coincide with a return; i_reti outside a handler is ignored.
    always_comb begin
        take_s = 1'b0;
        ret_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_s = win_valid_s & gie_q;
                ret_s  = 1'b0;
            end
            ST_ISR: begin
                take_s = 1'b0;
                ret_s  = i_reti;
            end
            default: begin
                take_s = 1'b0;
                ret_s  = 1'b0;
            end
        endcase
    end

    // Pending bits, context save and redirect target for the next edge.
    always_comb begin
        win_idx_s  = win_s - 5'd1;
        pend_d     = (pend_q | (rise_s & en_cur_s)) & en_nxt_s;
        saved_pc_d = saved_pc_q;
        saved_cc_d = saved_cc_q;
        iaddr_d    = iaddr_q;
        ctrl_d     = 1'b0;
        if (take_s) begin
            pend_d[win_idx_s] = 1'b0;
            saved_pc_d        = i_PC;
            saved_cc_d        = i_CCodes;
            iaddr_d           = vec_addr(VEC_BASE, VEC_SHIFT, win_s);
            ctrl_d            = 1'b1;
        end else if (ret_s) begin
            iaddr_d = saved_pc_q;
            ctrl_d  = 1'b1;
        end else begin
            ctrl_d = 1'b0;
        end
    end

    // All datapath and register-file flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gie_q      <= REG0_RST[GIE_BIT];
            for (int n = 1; n <= NUM_SRC; n++) begin
                cfg_q[n] <= CFG_RST;
            end
            ext_q      <= '0;
            pend_q     <= '0;
            saved_pc_q <= ADDR_RST;
            saved_cc_q <= CC_RST;
            iaddr_q    <= ADDR_RST;
            ctrl_q     <= 1'b0;
        end else begin
            gie_q      <= gie_d;
            for (int n = 1; n <= NUM_SRC; n++) begin
                cfg_q[n] <= cfg_d[n];
            end
            ext_q      <= ext_d;
            pend_q     <= pend_d;
            saved_pc_q <= saved_pc_d;
            saved_cc_q <= saved_cc_d;
            iaddr_q    <= iaddr_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign o_VIC_iaddr = iaddr_q;
    assign o_VIC_ctrl  = ctrl_q;
    assign o_CCodes    = saved_cc_q;

endmodule

// File: tb/tb_vic_ctrl.sv
// Directed scoreboard bench for vic_ctrl: stimulus pushes the expected
// redirect events, a negedge monitor pops and compares on every pulse.
module tb_vic_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] i_PC;
    logic [3:0]  i_VIC_data;
    logic [4:0]  i_VIC_regaddr;
    logic        i_VIC_we;
    logic [30:0] i_ext;
    logic        i_reti;
    logic [3:0]  i_CCodes;
    logic [3:0]  o_CCodes;
    logic [3:0]  o_VIC_data;
    logic [31:0] o_VIC_iaddr;
    logic        o_VIC_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  cc;
        logic        chk_cc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   pulse_cnt = 0;
    int   base_cnt;

    vic_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_PC          (i_PC),
        .i_VIC_data    (i_VIC_data),
        .i_VIC_regaddr (i_VIC_regaddr),
        .i_VIC_we      (i_VIC_we),
        .i_ext         (i_ext),
        .i_reti        (i_reti),
        .i_CCodes      (i_CCodes),
        .o_CCodes      (o_CCodes),
        .o_VIC_data    (o_VIC_data),
        .o_VIC_iaddr   (o_VIC_iaddr),
        .o_VIC_ctrl    (o_VIC_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every redirect pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst === 1'b1 && o_VIC_ctrl === 1'b1) begin
            pulse_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got iaddr=%h, expected no pulse", o_VIC_iaddr);
            end else begin
                mon_e = sb.pop_front();
                if (o_VIC_iaddr !== mon_e.addr || (mon_e.chk_cc && o_CCodes !== mon_e.cc)) begin
                    n_err++;
                    $display("FAIL redirect: got iaddr=%h cc=%b, expected iaddr=%h cc=%b (cc checked=%0d)",
                             o_VIC_iaddr, o_CCodes, mon_e.addr, mon_e.cc, mon_e.chk_cc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] d);
        i_VIC_regaddr = a;
        i_VIC_data    = d;
        i_VIC_we      = 1'b1;
        tick();
        i_VIC_we      = 1'b0;
    endtask

    task automatic chk_rd(input logic [4:0] a, input logic [3:0] exp, input string name);
        i_VIC_regaddr = a;
        #1;
        n_cmp++;
        if (o_VIC_data !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, o_VIC_data, exp);
        end
    endtask

    task automatic chk_val(input logic [31:0] got, input logic [31:0] exp, input string name);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] c, input logic chk);
        exp_t e;
        e.addr   = a;
        e.cc     = c;
        e.chk_cc = chk;
        sb.push_back(e);
    endtask

    // Wait for the scoreboard to empty; check the number of negedges taken.
    task automatic drain(input int exp_cyc, input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: timeout with %0d events outstanding, expected 0", name, sb.size());
            sb.delete();
        end else if (c != exp_cyc) begin
            n_err++;
            $display("FAIL %s: latency %0d cycles, expected %0d", name, c, exp_cyc);
        end
    endtask

    task automatic quiet(input int cycles, input string name);
        int b;
        b = pulse_cnt;
        repeat (cycles) tick();
        n_cmp++;
        if (pulse_cnt != b) begin
            n_err++;
            $display("FAIL %s: got %0d extra pulses, expected 0", name, pulse_cnt - b);
        end
    endtask

    initial begin
        rst           = 1'b0;
        i_PC          = 32'h0;
        i_VIC_data    = 4'h0;
        i_VIC_regaddr = 5'd0;
        i_VIC_we      = 1'b0;
        i_ext         = 31'h0;
        i_reti        = 1'b0;
        i_CCodes      = 4'h0;
        #12;
        chk_val({31'h0, o_VIC_ctrl}, 32'h0, "rst_ctrl");
        chk_val(o_VIC_iaddr, 32'h0, "rst_iaddr");
        chk_val({28'h0, o_CCodes}, 32'h0, "rst_cc");
        chk_rd(5'd0, 4'b0001, "rst_reg0");
        chk_rd(5'd5, 4'b0000, "rst_reg5");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Register file
        wr(5'd1, 4'b1100);
        chk_rd(5'd1, 4'b1100, "rd_reg1");
        wr(5'd31, 4'b1111);
        chk_rd(5'd31, 4'b1111, "rd_reg31");
        wr(5'd0, 4'b1110);
        chk_rd(5'd0, 4'b0000, "rd_reg0_masked");
        wr(5'd0, 4'b0001);
        chk_rd(5'd0, 4'b0001, "rd_reg0_gie");

        // Disabled source 2 never fires
        i_ext = 31'h2;
        quiet(20, "disabled_src2");
        i_ext = 31'h0;
        tick();

        // Entry on source 1, held level does not retrigger
        i_PC     = 32'h4;
        i_CCodes = 4'b1010;
        push(32'h84, 4'h0, 1'b0);
        i_ext = 31'h1;
        drain(3, "entry_src1");
        i_PC     = 32'h44;
        i_CCodes = 4'b0000;
        quiet(10, "held_ext");

        // Held return acts once
        push(32'h4, 4'b1010, 1'b1);
        i_reti = 1'b1;
        drain(2, "reti_src1");
        quiet(10, "held_reti");
        i_reti = 1'b0;
        i_ext  = 31'h0;
        tick();

        // Sources 1 and 31 together: priority 7 wins, then tail-chain to 1
        i_PC     = 32'h100;
        i_CCodes = 4'b0101;
        push(32'hFC, 4'h0, 1'b0);
        i_ext = 31'h4000_0001;
        drain(3, "prio_src31");
        push(32'h100, 4'b0101, 1'b1);
        push(32'h84, 4'h0, 1'b0);
        i_PC     = 32'h200;
        i_CCodes = 4'b0011;
        i_reti   = 1'b1;
        tick();
        i_reti = 1'b0;
        drain(2, "tail_chain");
        push(32'h200, 4'b0011, 1'b1);
        i_reti = 1'b1;
        tick();
        i_reti = 1'b0;
        drain(1, "reti_chained");
        i_ext = 31'h0;
        tick();

        // Equal priorities: lowest source number first
        wr(5'd2, 4'b1100);
        i_PC     = 32'h300;
        i_CCodes = 4'b0110;
        push(32'h84, 4'h0, 1'b0);
        i_ext = 31'h3;
        drain(3, "tie_lowest");

        // Request edge together with return: return first, then new winner
        push(32'h300, 4'b0110, 1'b1);
        push(32'hFC, 4'h0, 1'b0);
        i_PC     = 32'h380;
        i_CCodes = 4'b1100;
        i_ext    = 31'h4000_0003;
        i_reti   = 1'b1;
        tick();
        i_reti = 1'b0;
        drain(2, "ret_then_new");

        // Disabling source 2 drops its pending request
        wr(5'd2, 4'b0000);
        push(32'h380, 4'b1100, 1'b1);
        i_reti = 1'b1;
        tick();
        i_reti = 1'b0;
        drain(1, "reti_src31");
        quiet(10, "src2_cleared");
        i_ext = 31'h0;
        tick();

        // Reset in the middle of a handler
        i_CCodes = 4'b1001;
        push(32'h84, 4'h0, 1'b0);
        i_ext = 31'h1;
        drain(3, "entry_before_rst");
        rst = 1'b0;
        #2;
        chk_val({31'h0, o_VIC_ctrl}, 32'h0, "midrst_ctrl");
        chk_val(o_VIC_iaddr, 32'h0, "midrst_iaddr");
        chk_val({28'h0, o_CCodes}, 32'h0, "midrst_cc");
        chk_rd(5'd1, 4'b0000, "midrst_reg1");
        chk_rd(5'd0, 4'b0001, "midrst_reg0");
        i_ext = 31'h0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %0d outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vic_ctrl.md
Name: vic_ctrl

Overview:
- Vectored interrupt controller for the 32-bit core.
- Latches 31 external interrupt requests and arbitrates them by programmable priority.
- Redirects fetch to a per-source vector address, saving the interrupted PC and condition codes.
- Restores PC and condition codes on a return-from-interrupt.
- Sits beside the fetch/PC-select stage; exposes a 32 x 4-bit register file to the core via a register-style port.

Parameters:
- VEC_BASE, 32'h0000_0080, base address of the vector table.
- VEC_SHIFT, 2, log2 of the vector stride in bytes; vector for source n = VEC_BASE + (n << VEC_SHIFT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_PC  in  32  PC to save when an interrupt is taken.
- i_VIC_data  in  4  register write data.
- i_VIC_regaddr  in  5  register address for read and write.
- i_VIC_we  in  1  register write enable.
- i_ext  in  31  external requests; i_ext[k] is source n = k+1.
- i_reti  in  1  return-from-interrupt strobe.
- i_CCodes  in  4  current condition codes (saved on entry).
- o_CCodes  out  4  saved condition codes (restored on return).
- o_VIC_data  out  4  read data of register i_VIC_regaddr.
- o_VIC_iaddr  out  32  redirect target address.
- o_VIC_ctrl  out  1  one-cycle pulse: fetch loads o_VIC_iaddr.

Behaviour:
- Clocking and reset: one clock domain (clk); rst is asynchronous, active-low.
- Register file:
  - reg0 = global control; bit0 = global enable (GIE); bits[3:1] read 0, writes ignored.
  - reg n (1..31) = config of source n; bit3 = enable, bits[2:0] = priority (7 highest).
  - Write on rising clk when i_VIC_we=1.
  - o_VIC_data = combinational read of reg[i_VIC_regaddr].
- Reset values:
  - reg0 = 4'b0001; reg1..31 = 0; all pending bits, in_isr, saved_pc and saved_cc = 0.
  - o_VIC_ctrl = 0, o_VIC_iaddr = 0, o_CCodes = 0.
- Request capture:
  - i_ext is registered into ext_q.
  - Pending[n] is set when i_ext[n-1]=1, ext_q[n-1]=0 (rising edge) and enable(n)=1.
  - Level-held requests do not re-trigger.
  - Clearing enable(n) by a write clears pending[n] in the same cycle.
- Arbitration (combinational): among pending sources, the highest priority wins; ties go to the lowest n.
- Take condition: a winner exists, GIE=1, in_isr=0 and no return is executing this cycle. On that rising edge:
  - saved_pc <= i_PC; saved_cc <= i_CCodes; in_isr <= 1; pending[winner] <= 0.
  - o_VIC_iaddr <= VEC_BASE + (winner << VEC_SHIFT); o_VIC_ctrl <= 1.
- Return: on a rising edge with i_reti=1 and in_isr=1:
  - o_VIC_iaddr <= saved_pc; o_VIC_ctrl <= 1; in_isr <= 0.
  - o_CCodes is driven from saved_cc (valid during this pulse).
  - i_reti with in_isr=0 is ignored, so a held i_reti acts once.
- o_VIC_ctrl is high exactly one cycle per event, then returns to 0; o_VIC_iaddr holds its last value.
- Entry latency: the edge occurs at clk k; pending is set at the edge of k+1; o_VIC_ctrl is high during cycle k+2.
- No nesting: edges arriving while in_isr=1 stay pending and are taken on the cycle after the return pulse (tail-chaining).
- Simultaneous request edge and return: the return is processed first; the new request is taken next.
- Writes to reg0 bits[3:1] have no effect.
- A reset mid-service drops all state to reset values immediately.

Decomposition:
- Package vic_pkg: register-field constants (EN_BIT=3, PRIO_MSB=2, GIE_BIT=0), NUM_SRC=31, reset constants.
- Sub-module vic_arbiter: combinational priority/lowest-index selector over 31 {pending, prio} pairs, returning valid + 5-bit winner.
- Top level holds the register file, edge detect, pending bits and the entry/return sequencing.

Test Plan:
- Reset (rst=0) -> o_VIC_ctrl=0, o_VIC_iaddr=0, o_CCodes=0; read addr0 gives o_VIC_data=4'b0001, addr5 gives 0.
- Write reg1=4'b1100 and reg31=4'b1111 -> readback 4'b1100 / 4'b1111; write reg0=4'b1110 -> reads 4'b0000.
- After reg1=1100, drive i_ext=2 (source 2 disabled) -> o_VIC_ctrl stays 0 indefinitely.
- Drive i_ext=1 with i_PC=4, i_CCodes=4'b1010 -> o_VIC_ctrl pulses once, o_VIC_iaddr=32'h84; a held i_ext causes no second pulse.
- Then i_reti=1 held -> single pulse, o_VIC_iaddr=32'h4, o_CCodes=4'b1010; no further pulses.
- reg1=1100, reg31=1111, rising i_ext=31'h40000001 in the same cycle -> vector 32'h0FC taken first; after reti, vector 32'h84 is taken on the next cycle.
